// File: rtl/ncl_tb_pkg.sv
// Shared NCL boundary types: FSM states, dual-rail codes, defaults.
// Used by the sync->NCL driver and the matching NCL->sync receiver.
package ncl_tb_pkg;

  localparam int NCL_WIDTH       = 4;
  localparam int NCL_SYNC_STAGES = 2;
  localparam int NCL_TIMEOUT     = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DATA     = 2'd1,
    ST_NULL_RET = 2'd2
  } ncl_state_e;

  // Dual-rail codes as {rail_t, rail_f}.
  localparam logic [1:0] DR_NULL  = 2'b00;
  localparam logic [1:0] DR_DATA0 = 2'b01;
  localparam logic [1:0] DR_DATA1 = 2'b10;

  function automatic logic [1:0] dr_enc(
    input logic b
  );
    return b ? DR_DATA1 : DR_DATA0;
  endfunction

endpackage

// File: rtl/ncl_ki_sync.sv
// STAGES-deep synchronizer for the asynchronous ki completion input.
// Ports: clk, rst_n (async clear), d (async in), q (synchronized out).
module ncl_ki_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("ncl_ki_sync: STAGES out of range");
  end

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ncl_sync_dr_tx.sv
// Clocked-to-NCL driver: valid/ready words out as dual-rail DATA/NULL.
// Ports: in_valid/in_ready/in_data, rail_t/rail_f, ki, busy, timeout_err, wave_count.
module ncl_sync_dr_tx
  import ncl_tb_pkg::*;
#(
  parameter int WIDTH       = NCL_WIDTH,
  parameter int SYNC_STAGES = NCL_SYNC_STAGES,
  parameter int TIMEOUT     = NCL_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] rail_t,
  output logic [WIDTH-1:0] rail_f,
  input  logic             ki,
  output logic             busy,
  output logic             timeout_err,
  output logic [15:0]      wave_count
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_tmo
    $error("ncl_sync_dr_tx: TIMEOUT out of range");
  end

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

  ncl_state_e       state_q;
  ncl_state_e       state_d;
  logic             ki_s;
  logic             accept;
  logic             drop;
  logic             tmo_run;
  logic [15:0]      tmo_q;
  logic [WIDTH-1:0] enc_t;
  logic [WIDTH-1:0] enc_f;

  ncl_ki_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ki_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ki),
    .q     (ki_s)
  );

  always_comb begin
    enc_t = '0;
    enc_f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {enc_t[i], enc_f[i]} = dr_enc(in_data[i]);
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign in_ready = (state_q == ST_IDLE) && ki_s;
  assign accept   = in_valid && in_ready;
  assign drop     = (state_q == ST_DATA) && !ki_s;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept) state_d = ST_DATA;
      ST_DATA:     if (!ki_s)  state_d = ST_NULL_RET;
      ST_NULL_RET: if (ki_s)   state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Counter runs only while a wavefront waits in the same state.
  assign tmo_run = busy && (state_d == state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Whole word is loaded from one register so DATA is always complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rail_t     <= '0;
      rail_f     <= '0;
      wave_count <= '0;
    end else if (accept) begin
      rail_t <= enc_t;
      rail_f <= enc_f;
    end else if (drop) begin
      rail_t     <= '0;
      rail_f     <= '0;
      wave_count <= wave_count + 16'd1;
    end else if (state_d == ST_IDLE) begin
      rail_t <= '0;
      rail_f <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (!tmo_run) begin
      tmo_q <= '0;
    end else if (tmo_q != TMO_LIM) begin
      tmo_q <= tmo_q + 16'd1;
    end
  end

  // Flag on the edge where the count reaches the limit; FSM keeps waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (tmo_run && (tmo_q + 16'd1 == TMO_LIM)) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ncl_sync_dr_tx.sv
// Directed bench for ncl_sync_dr_tx: vector table plus corner sequences.
// Covers handshake, ki protocol, streaming, timeout, async reset, wrap.
module tb_ncl_sync_dr_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = 4'h0;
  logic [3:0]  rail_t;
  logic [3:0]  rail_f;
  logic        ki;
  logic        ki_man = 1'b1;
  logic        ki_model;
  logic        model_en = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic [15:0] wave_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign ki = model_en ? ki_model : ki_man;

  ncl_sync_dr_tx #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .TIMEOUT     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .rail_t      (rail_t),
    .rail_f      (rail_f),
    .ki          (ki),
    .busy        (busy),
    .timeout_err (timeout_err),
    .wave_count  (wave_count)
  );

  // Downstream completion model: complete DATA -> ki=0, NULL -> ki=1,
  // after a 3-cycle delay.
  logic [2:0] kp;
  always @(posedge clk) begin
    if (!model_en) kp <= 3'b111;
    else if (&(rail_t | rail_f)) kp <= {kp[1:0], 1'b0};
    else if ((rail_t | rail_f) == 4'h0) kp <= {kp[1:0], 1'b1};
    else kp <= {kp[1:0], kp[0]};
  end
  assign ki_model = kp[2];

  // Wavefront monitor.
  logic       mon_en = 1'b0;
  logic       prev_null = 1'b1;
  int         inv_err = 0;
  logic [3:0] seen[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if ((rail_t & rail_f) != 4'h0) inv_err++;
      if (!(&(rail_t | rail_f)) && ((rail_t | rail_f) != 4'h0)) inv_err++;
      if (&(rail_t | rail_f) && prev_null) seen.push_back(rail_t);
      prev_null = ((rail_t | rail_f) == 4'h0);
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_en = 1'b0;
    ki_man = 1'b1;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_null(input string name);
    int n = 0;
    while (((rail_t | rail_f) != 4'h0) && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'({rail_t, rail_f}), 32'd0);
  endtask

  task automatic do_wave(input logic [3:0] w);
    wait_ready("wave_ready");
    in_valid = 1'b1;
    in_data = w;
    tick();
    in_valid = 1'b0;
    ki_man = 1'b0;
    wait_null("wave_null");
    ki_man = 1'b1;
    wait_ready("wave_idle");
  endtask

  typedef struct {
    logic        ki;
    logic        v;
    logic [3:0]  d;
    logic        rdy;
    logic [3:0]  t;
    logic [3:0]  f;
    logic        bsy;
    logic [15:0] wc;
  } vec_t;

  vec_t       tbl[21];
  logic [3:0] words[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ki, valid, data | ready, rail_t, rail_f, busy, wave_count
    tbl[0]  = '{1'b1, 1'b0, 4'hA, 1'b0, 4'h0, 4'h0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'hA, 1'b1, 4'h0, 4'h0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 4'hA, 1'b0, 4'hA, 4'h5, 1'b1, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 4'hF, 1'b0, 4'hA, 4'h5, 1'b1, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 4'hF, 1'b0, 4'hA, 4'h5, 1'b1, 16'd0};
    tbl[5]  = '{1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 16'd1};
    tbl[6]  = '{1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 16'd1};
    tbl[7]  = '{1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 16'd1};
    tbl[8]  = '{1'b1, 1'b1, 4'h3, 1'b1, 4'h0, 4'h0, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 1'b1, 4'h3, 1'b0, 4'h3, 4'hC, 1'b1, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 4'h3, 1'b0, 4'h3, 4'hC, 1'b1, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 4'h3, 1'b0, 4'h3, 4'hC, 1'b1, 16'd1};
    tbl[12] = '{1'b0, 1'b0, 4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 16'd2};
    tbl[13] = '{1'b1, 1'b0, 4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 16'd2};
    tbl[14] = '{1'b1, 1'b0, 4'h3, 1'b0, 4'h0, 4'h0, 1'b1, 16'd2};
    tbl[15] = '{1'b0, 1'b0, 4'h3, 1'b1, 4'h0, 4'h0, 1'b0, 16'd2};
    tbl[16] = '{1'b0, 1'b1, 4'h9, 1'b0, 4'h9, 4'h6, 1'b1, 16'd2};
    tbl[17] = '{1'b0, 1'b0, 4'h9, 1'b0, 4'h0, 4'h0, 1'b1, 16'd3};
    tbl[18] = '{1'b1, 1'b0, 4'h9, 1'b0, 4'h0, 4'h0, 1'b1, 16'd3};
    tbl[19] = '{1'b1, 1'b0, 4'h9, 1'b0, 4'h0, 4'h0, 1'b1, 16'd3};
    tbl[20] = '{1'b1, 1'b0, 4'h9, 1'b1, 4'h0, 4'h0, 1'b0, 16'd3};
    words[0] = 4'h0;
    words[1] = 4'hF;
    words[2] = 4'h6;

    // Reset state
    do_reset();
    check("reset_outputs",
          32'({in_ready, rail_t, rail_f, busy, timeout_err, wave_count}),
          32'd0);

    // Handshake / ki protocol table
    for (int i = 0; i < 21; i++) begin
      ki_man = tbl[i].ki;
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      tick();
      check($sformatf("vec%0d", i),
            32'({in_ready, rail_t, rail_f, busy, wave_count}),
            32'({tbl[i].rdy, tbl[i].t, tbl[i].f, tbl[i].bsy, tbl[i].wc}));
    end
    in_valid = 1'b0;
    check("table_no_timeout", 32'(timeout_err), 32'd0);

    // Stream three words against the completion model
    do_reset();
    model_en = 1'b1;
    prev_null = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready($sformatf("stream_ready%0d", i));
      in_valid = 1'b1;
      in_data = words[i];
      tick();
      in_valid = 1'b0;
    end
    begin
      int n = 0;
      while (!(in_ready && !busy && wave_count == 16'd3) && n < 80) begin
        tick();
        n++;
      end
    end
    mon_en = 1'b0;
    check("stream_wave_count", 32'(wave_count), 32'd3);
    check("stream_n_waves", 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++)
      check($sformatf("stream_word%0d", i), 32'(seen[i]), 32'(words[i]));
    check("stream_rail_invariant", 32'(inv_err), 32'd0);
    check("stream_no_timeout", 32'(timeout_err), 32'd0);

    // Timeout with ki stuck high in DATA
    do_reset();
    wait_ready("tmo_ready");
    in_valid = 1'b1;
    in_data = 4'h5;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("tmo_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("tmo_flag", 32'(timeout_err), 32'd1);
    check("tmo_rails_held", 32'({rail_t, rail_f, busy}), 32'({4'h5, 4'hA, 1'b1}));
    ki_man = 1'b0;
    wait_null("tmo_null");
    ki_man = 1'b1;
    wait_ready("tmo_idle");
    check("tmo_wave_count", 32'(wave_count), 32'd1);
    check("tmo_sticky", 32'(timeout_err), 32'd1);

    // Async reset in the middle of a DATA wavefront
    do_reset();
    do_wave(4'hA);
    in_valid = 1'b1;
    in_data = 4'hC;
    tick();
    in_valid = 1'b0;
    check("rst_pre_data", 32'({rail_t, rail_f, wave_count}),
          32'({4'hC, 4'h3, 16'd1}));
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_rails", 32'({rail_t, rail_f}), 32'd0);
    check("rst_async_status", 32'({in_ready, busy, wave_count}), 32'd0);

    // wave_count wrap
    do_reset();
    wait_ready("wrap_ready");
    force dut.wave_count = 16'hFFFE;
    #1 release dut.wave_count;
    check("wrap_preload", 32'(wave_count), 32'hFFFE);
    do_wave(4'h6);
    check("wrap_ffff", 32'(wave_count), 32'hFFFF);
    do_wave(4'h9);
    check("wrap_zero", 32'(wave_count), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
